// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency RAM between the
// instruction-fetch port and the data-memory port. Each granted access is
// latched, driven to the RAM for LAT cycles and completed with a one-cycle
// hit pulse plus registered load data. Contending requests alternate
// round-robin, with data winning the first contention after reset.
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam logic       GRANT_I  = 1'b0;
  localparam logic       GRANT_D  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IBUSY = 3'd1,
    DBUSY = 3'd2,
    IHIT  = 3'd3,
    DHIT  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic        last_grant_r;
  logic [31:0] addr_r;
  logic [31:0] store_r;
  logic        write_r;
  logic        ihit_r;
  logic        dhit_r;
  logic [31:0] iload_r;
  logic [31:0] dload_r;
  logic        ram_ren_r;
  logic        ram_wen_r;

  logic        d_req_s;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        done_s;
  logic        busy_s;
  logic        write_next_s;
  logic        busy_next_s;
  logic        ram_ren_s;
  logic        ram_wen_s;
  logic        ihit_s;
  logic        dhit_s;

  assign d_req_s = dREN | dWEN;
  assign busy_s  = (state_r == IBUSY) || (state_r == DBUSY);

  // Next-state logic: arbitration in IDLE, latency countdown in BUSY, single HIT cycle
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req_s && iREN) begin
          if (last_grant_r == GRANT_I) begin
            grant_d_s = 1'b1;
          end else begin
            grant_i_s = 1'b1;
          end
        end else if (d_req_s) begin
          grant_d_s = 1'b1;
        end else if (iREN) begin
          grant_i_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_d_s) begin
          state_s = DBUSY;
        end else if (grant_i_s) begin
          state_s = IBUSY;
        end else begin
          state_s = IDLE;
        end
      end
      IBUSY: begin
        if (cnt_r == 4'd0) begin
          state_s = IHIT;
          done_s  = 1'b1;
        end else begin
          state_s = IBUSY;
        end
      end
      DBUSY: begin
        if (cnt_r == 4'd0) begin
          state_s = DHIT;
          done_s  = 1'b1;
        end else begin
          state_s = DBUSY;
        end
      end
      IHIT:    state_s = IDLE;
      DHIT:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the granted access and run the latency counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_r  <= 32'h0000_0000;
      store_r <= 32'h0000_0000;
      write_r <= 1'b0;
      cnt_r   <= 4'd0;
    end else if (grant_d_s) begin
      addr_r  <= daddr;
      store_r <= dstore;
      write_r <= dWEN;
      cnt_r   <= CNT_INIT;
    end else if (grant_i_s) begin
      addr_r  <= iaddr;
      store_r <= dstore;
      write_r <= 1'b0;
      cnt_r   <= CNT_INIT;
    end else if (busy_s && (cnt_r != 4'd0)) begin
      cnt_r   <= cnt_r - 4'd1;
    end
  end

  // Remember which port finished last so contention alternates
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_r <= GRANT_I;
    end else if (done_s) begin
      last_grant_r <= (state_r == DBUSY) ? GRANT_D : GRANT_I;
    end
  end

  // Capture RAM read data on the last BUSY cycle; writes leave dload alone
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload_r <= 32'h0000_0000;
      dload_r <= 32'h0000_0000;
    end else if (done_s && !write_r) begin
      if (state_r == IBUSY) begin
        iload_r <= ramload;
      end else begin
        dload_r <= ramload;
      end
    end
  end

  // Output decode: strobes and hits for the cycle that follows this edge
  always_comb begin
    write_next_s = write_r;
    if (grant_d_s) begin
      write_next_s = dWEN;
    end else if (grant_i_s) begin
      write_next_s = 1'b0;
    end else begin
      write_next_s = write_r;
    end
    busy_next_s = (state_s == IBUSY) || (state_s == DBUSY);
    ram_ren_s   = busy_next_s && !write_next_s;
    ram_wen_s   = busy_next_s && write_next_s;
    ihit_s      = (state_s == IHIT);
    dhit_s      = (state_s == DHIT);
  end

  // Output registers so strobes and hits leave the block glitch-free
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ram_ren_r <= 1'b0;
      ram_wen_r <= 1'b0;
      ihit_r    <= 1'b0;
      dhit_r    <= 1'b0;
    end else begin
      ram_ren_r <= ram_ren_s;
      ram_wen_r <= ram_wen_s;
      ihit_r    <= ihit_s;
      dhit_r    <= dhit_s;
    end
  end

  assign ramREN   = ram_ren_r;
  assign ramWEN   = ram_wen_r;
  assign ramaddr  = addr_r;
  assign ramstore = store_r;
  assign ihit     = ihit_r;
  assign dhit     = dhit_r;
  assign iload    = iload_r;
  assign dload    = dload_r;

endmodule
